// File: rtl/vga_text_ctrl.sv
// Text-mode write controller: turns decoded ASCII strobes into character RAM writes,
// tracks the cursor and scrolls by rotating top_row. Optional macro: CURSOR_BLINK_EN.
module vga_text_ctrl #(
    parameter int COLS      = 70,
    parameter int ROWS      = 30,
    parameter int ADDR_W    = 12,
    parameter int BLINK_DIV = 12500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [7:0]        key_ascii,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic [4:0]        top_row,
    output logic              cursor_on,
    output logic              busy,
    output logic              overflow
);

    localparam int CELLS = COLS * ROWS;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [6:0]        clr_cnt_q, clr_cnt_d;
    logic              pend_full_q, pend_full_d;
    logic [7:0]        pend_data_q, pend_data_d;
    logic [6:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [4:0]        top_q, top_d;
    logic              ovf_q, ovf_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    logic              consume;
    logic              key_accept;
    logic              new_line;

    // Screen row to physical RAM row; top + row < 2*ROWS so one conditional subtract suffices.
    function automatic logic [4:0] phys_of(input logic [4:0] top, input logic [4:0] r);
        logic [5:0] s;
        s = {1'b0, top} + {1'b0, r};
        if (s >= 6'(ROWS)) begin
            s = s - 6'(ROWS);
        end
        return s[4:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] c);
        return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_INIT;
            sweep_q     <= '0;
            clr_cnt_q   <= '0;
            pend_full_q <= 1'b0;
            pend_data_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
            top_q       <= '0;
            ovf_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            clr_cnt_q   <= clr_cnt_d;
            pend_full_q <= pend_full_d;
            pend_data_q <= pend_data_d;
            col_q       <= col_d;
            row_q       <= row_d;
            top_q       <= top_d;
            ovf_q       <= ovf_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        clr_cnt_d = clr_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        top_d     = top_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        consume   = 1'b0;
        new_line  = 1'b0;

        case (state_q)
            S_INIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = sweep_q;
                wr_data_d = 8'h20;
                if (sweep_q == ADDR_W'(CELLS - 1)) begin
                    sweep_d = '0;
                    state_d = S_IDLE;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end

            S_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = sweep_q;
                wr_data_d = 8'h20;
                sweep_d   = sweep_q + 1'b1;
                if (clr_cnt_q == 7'(COLS - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end

            default: begin
                if (pend_full_q) begin
                    consume = 1'b1;
                    if (pend_data_q >= 8'h20 && pend_data_q <= 8'h7E) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cell_addr(phys_of(top_q, row_q), col_q);
                        wr_data_d = pend_data_q;
                        if (col_q == 7'(COLS - 1)) begin
                            col_d    = '0;
                            new_line = 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else if (pend_data_q == 8'h0A || pend_data_q == 8'h0D) begin
                        col_d    = '0;
                        new_line = 1'b1;
                    end else if (pend_data_q == 8'h08) begin
                        if (col_q != '0) begin
                            col_d     = col_q - 1'b1;
                            wr_en_d   = 1'b1;
                            wr_addr_d = cell_addr(phys_of(top_q, row_q), col_q - 1'b1);
                            wr_data_d = 8'h20;
                        end else if (row_q != '0) begin
                            row_d     = row_q - 1'b1;
                            col_d     = 7'(COLS - 1);
                            wr_en_d   = 1'b1;
                            wr_addr_d = cell_addr(phys_of(top_q, row_q - 1'b1), 7'(COLS - 1));
                            wr_data_d = 8'h20;
                        end
                    end

                    // At the bottom line the old top row is recycled as the new bottom line.
                    if (new_line) begin
                        if (row_q < 5'(ROWS - 1)) begin
                            row_d = row_q + 1'b1;
                        end else begin
                            top_d     = (top_q == 5'(ROWS - 1)) ? 5'd0 : top_q + 1'b1;
                            sweep_d   = cell_addr(top_q, 7'd0);
                            clr_cnt_d = '0;
                            state_d   = S_CLEAR;
                        end
                    end
                end
            end
        endcase
    end

    // A full buffer can still take a new key in the same cycle it is being consumed.
    assign key_accept = key_valid && (!pend_full_q || consume);

    always_comb begin
        pend_full_d = pend_full_q;
        pend_data_d = pend_data_q;
        ovf_d       = ovf_q;
        if (key_accept) begin
            pend_full_d = 1'b1;
            pend_data_d = key_ascii;
        end else begin
            if (consume) begin
                pend_full_d = 1'b0;
            end
            if (key_valid) begin
                ovf_d = 1'b1;
            end
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          cursor_on_q, cursor_on_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        cursor_on_d = cursor_on_q;
        if (key_accept) begin
            blink_cnt_d = '0;
            cursor_on_d = 1'b1;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            cursor_on_d = ~cursor_on_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            cursor_on_q <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            cursor_on_q <= cursor_on_d;
        end
    end

    assign cursor_on = cursor_on_q;
`else
    assign cursor_on = 1'b1;
`endif

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign top_row    = top_q;
    assign busy       = (state_q != S_IDLE);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed bench for vga_text_ctrl: init sweep, typing, wrap, backspace, scroll,
// buffer overflow and reset restart, with hand-computed expectations.
module tb_vga_text_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [7:0]  key_ascii;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [4:0]  top_row;
    logic        cursor_on;
    logic        busy;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    vga_text_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ascii  (key_ascii),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .top_row    (top_row),
        .cursor_on  (cursor_on),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe one key, then step to the edge where an idle controller consumes it.
    task automatic send_key(input logic [7:0] c);
        key_valid = 1'b1;
        key_ascii = c;
        tick();
        key_valid = 1'b0;
        tick();
    endtask

    // Follow a sweep while busy; each cycle must show the next 0x20 write.
    task automatic sweep_chk(input string tag, input int base, input int len);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        while (busy === 1'b1 && n < len + 10) begin
            n++;
            tick();
            if (!(wr_en === 1'b1 && wr_addr === 12'(base + n - 1) && wr_data === 8'h20)) begin
                bad++;
            end
        end
        chk({tag, "_len"}, n, len);
        chk({tag, "_data"}, bad, 0);
    endtask

    task automatic chk_write(input string tag, input int addr, input logic [7:0] data);
        chk({tag, "_wr_en"}, wr_en, 1);
        chk({tag, "_addr"}, wr_addr, addr);
        chk({tag, "_data"}, wr_data, data);
    endtask

    task automatic chk_cursor(input string tag, input int col, input int row);
        chk({tag, "_col"}, cursor_col, col);
        chk({tag, "_row"}, cursor_row, row);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        tick();
        tick();
        tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk_cursor("rst", 0, 0);
        chk("rst_top", top_row, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_cursor_on", cursor_on, 1);

        rst = 1'b1;
        sweep_chk("init", 0, 2100);
        chk_cursor("init", 0, 0);
        tick();
        chk("init_done_wr_en", wr_en, 0);

        send_key(8'h41);
        chk_write("keyA", 0, 8'h41);
        chk_cursor("keyA", 1, 0);

        for (int i = 1; i < 70; i++) begin
            send_key(8'(8'h30 + i % 10));
        end
        chk_write("wrap", 69, 8'h39);
        chk_cursor("wrap", 0, 1);

        send_key(8'h0A);
        chk("lf_wr_en", wr_en, 0);
        chk_cursor("lf", 0, 2);

        send_key(8'h01);
        chk("ctl_wr_en", wr_en, 0);
        chk_cursor("ctl", 0, 2);

        send_key(8'h08);
        chk_write("bs_row", 139, 8'h20);
        chk_cursor("bs_row", 69, 1);

        send_key(8'h0D);
        chk_cursor("cr", 0, 2);
        send_key(8'h42);
        chk_write("keyB", 140, 8'h42);
        send_key(8'h08);
        chk_write("bs_col", 140, 8'h20);
        chk_cursor("bs_col", 0, 2);

        for (int i = 0; i < 3; i++) begin
            send_key(8'h0A);
        end
        send_key(8'h08);
        chk_write("bs_r5", 349, 8'h20);
        chk_cursor("bs_r5", 69, 4);
        send_key(8'h0D);
        chk_cursor("cr_r5", 0, 5);

        for (int i = 0; i < 24; i++) begin
            send_key(8'h0A);
        end
        chk_cursor("bottom", 0, 29);
        chk("bottom_top", top_row, 0);

        send_key(8'h0D);
        chk("scroll_top", top_row, 1);
        chk_cursor("scroll", 0, 29);
        chk("scroll_wr_en", wr_en, 0);
        chk("scroll_busy", busy, 1);
        sweep_chk("clear1", 0, 70);
        chk("clear1_ovf", overflow, 0);

        send_key(8'h42);
        chk_write("scrolled_B", 0, 8'h42);
        chk_cursor("scrolled_B", 1, 29);

        // Three keys on back-to-back edges: CR, then 'C' taken as CR is consumed, then 'D' dropped.
        key_valid = 1'b1;
        key_ascii = 8'h0D;
        tick();
        key_ascii = 8'h43;
        tick();
        chk("ovf_top", top_row, 2);
        chk("ovf_busy", busy, 1);
        key_ascii = 8'h44;
        tick();
        key_valid = 1'b0;
        chk("ovf_set", overflow, 1);
        for (int n = 0; n < 200 && busy === 1'b1; n++) begin
            tick();
        end
        chk("ovf_clear_done", busy, 0);
        tick();
        chk_write("ovf_keyC", 70, 8'h43);
        chk_cursor("ovf_keyC", 1, 29);
        tick();
        chk("ovf_dropD_wr_en", wr_en, 0);
        chk_cursor("ovf_dropD", 1, 29);
        chk("ovf_sticky", overflow, 1);

        rst = 1'b0;
        tick();
        tick();
        chk("rst2_ovf", overflow, 0);
        chk("rst2_top", top_row, 0);
        chk_cursor("rst2", 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        rst = 1'b0;
        tick();
        chk("rst3_wr_en", wr_en, 0);
        rst = 1'b1;
        sweep_chk("reinit", 0, 2100);
        tick();

        send_key(8'h08);
        chk("bs00_wr_en", wr_en, 0);
        chk_cursor("bs00", 0, 0);
        chk("bs00_top", top_row, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
